// File: rtl/led_mode_ctrl.sv
// led_mode_ctrl: four-key debounced pattern/speed/pause controller driving a 4-LED board
//   sys_clk    in   system clock
//   sys_res_n  in   synchronous active-low reset
//   key[3:0]   in   raw active-low buttons: [0] next mode, [1] speed up, [2] speed down, [3] pause/run
//   led[3:0]   out  LED drive, 1 = on
//   mode[1:0]  out  0 FLOW_L, 1 FLOW_R, 2 BLINK, 3 PINGPONG
//   speed[1:0] out  speed level 0..3, step period BASE_TICK >> speed
//   running    out  1 = stepping, 0 = paused
module led_mode_ctrl #(
    parameter int BASE_TICK = 10_000_000,
    parameter int DEB_CNT   = 1_000_000
) (
    input  logic       sys_clk,
    input  logic       sys_res_n,
    input  logic [3:0] key,
    output logic [3:0] led,
    output logic [1:0] mode,
    output logic [1:0] speed,
    output logic       running
);
    localparam int DW = $clog2(DEB_CNT + 1);
    localparam logic [DW-1:0] DEB_MAX = DW'(DEB_CNT - 1);
    localparam logic [23:0] BT = 24'(BASE_TICK);

    typedef enum logic [1:0] {FLOW_L, FLOW_R, BLINK, PINGPONG} mode_t;

    mode_t         mode_q, mode_d;
    logic [3:0]    sync1_q, sync2_q, lvl_q, lvl_d, press_q, press_d;
    logic [DW-1:0] deb_q [4];
    logic [DW-1:0] deb_d [4];
    logic [23:0]   cnt_q, cnt_d, period;
    logic [3:0]    led_q, led_d, shl, shr, pp;
    logic [1:0]    speed_q, speed_d;
    logic          running_q, running_d, dir_q, dir_d;
    logic          tick, m_p, p_p, u_p, d_p;

    // A key's accepted level only moves after DEB_CNT consecutive disagreeing samples.
    always_comb begin
        lvl_d = lvl_q;
        for (int i = 0; i < 4; i++) begin
            deb_d[i] = '0;
            if (sync2_q[i] != lvl_q[i]) begin
                if (deb_q[i] == DEB_MAX) lvl_d[i] = sync2_q[i];
                else deb_d[i] = deb_q[i] + DW'(1);
            end
        end
        press_d = lvl_q & ~lvl_d;
    end

    always_comb begin
        m_p       = press_q[0];
        p_p       = press_q[3] & ~press_q[0];
        u_p       = press_q[1] & ~press_q[0] & ~press_q[3];
        d_p       = press_q[2] & ~press_q[0] & ~press_q[3] & ~press_q[1];
        period    = BT >> speed_q;
        tick      = running_q && (cnt_q == period - 24'd1);
        shl       = {led_q[2:0], led_q[3]};
        shr       = {led_q[0], led_q[3:1]};
        pp        = dir_q ? {1'b0, led_q[3:1]} : {led_q[2:0], 1'b0};
        running_d = running_q ^ p_p;
        speed_d   = (u_p && speed_q != 2'd3) ? speed_q + 2'd1 :
                    (d_p && speed_q != 2'd0) ? speed_q - 2'd1 : speed_q;
        // Clearing on any accepted speed pulse keeps the count below a newly shortened period.
        cnt_d     = (m_p || u_p || d_p) ? '0 : !running_q ? cnt_q : tick ? '0 : cnt_q + 24'd1;
        mode_d    = m_p ? mode_t'(mode_q + 2'd1) : mode_q;
        led_d     = m_p ? (mode_d == BLINK ? 4'b0000 : 4'b0001) :
                    !tick ? led_q :
                    mode_q == FLOW_L ? shl :
                    mode_q == FLOW_R ? shr :
                    mode_q == BLINK  ? ~led_q : pp;
        dir_d     = m_p ? 1'b0 :
                    (tick && mode_q == PINGPONG) ? (pp == 4'b1000 ? 1'b1 : pp == 4'b0001 ? 1'b0 : dir_q) :
                    dir_q;
    end

    always_ff @(posedge sys_clk) begin
        if (!sys_res_n) begin
            sync1_q   <= 4'hF;
            sync2_q   <= 4'hF;
            lvl_q     <= 4'hF;
            press_q   <= '0;
            deb_q     <= '{default: '0};
            cnt_q     <= '0;
            led_q     <= 4'b0001;
            mode_q    <= FLOW_L;
            speed_q   <= '0;
            running_q <= 1'b1;
            dir_q     <= 1'b0;
        end else begin
            sync1_q   <= key;
            sync2_q   <= sync1_q;
            lvl_q     <= lvl_d;
            press_q   <= press_d;
            deb_q     <= deb_d;
            cnt_q     <= cnt_d;
            led_q     <= led_d;
            mode_q    <= mode_d;
            speed_q   <= speed_d;
            running_q <= running_d;
            dir_q     <= dir_d;
        end
    end

    assign led     = led_q;
    assign mode    = mode_q;
    assign speed   = speed_q;
    assign running = running_q;
endmodule

// File: tb/tb_led_mode_ctrl.sv
// tb_led_mode_ctrl: vector table, corner sequences and random keys against a pattern-index model
module tb_led_mode_ctrl;
    localparam int BT = 16;
    localparam int DC = 4;

    logic       clk;
    logic       res_n;
    logic [3:0] key;
    logic [3:0] led;
    logic [1:0] mode;
    logic [1:0] speed;
    logic       running;

    int checks = 0;
    int errors = 0;

    led_mode_ctrl #(.BASE_TICK(BT), .DEB_CNT(DC)) dut (
        .sys_clk(clk),
        .sys_res_n(res_n),
        .key(key),
        .led(led),
        .mode(mode),
        .speed(speed),
        .running(running)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Model: pattern position index since last mode change, elapsed cycles in the current step,
    // and a raw-sample history for the key filter.
    int         m_mode, m_speed, m_idx, m_elapsed;
    logic       m_run;
    logic [3:0] acc, pend;
    logic [3:0] hist [8];

    function automatic logic [3:0] mled();
        int k;
        logic [3:0] ppt [6];
        ppt = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0100, 4'b0010};
        case (m_mode)
            0: mled = 4'(1 << (m_idx % 4));
            1: begin
                k = m_idx % 4;
                mled = (k == 0) ? 4'b0001 : 4'(1 << (4 - k));
            end
            2: mled = (m_idx % 2 == 1) ? 4'b1111 : 4'b0000;
            default: mled = ppt[m_idx % 6];
        endcase
    endfunction

    task automatic model_edge();
        logic tk, mc, pc, uc, dc, diff;
        logic [3:0] np;
        if (!res_n) begin
            m_mode = 0; m_speed = 0; m_idx = 0; m_elapsed = 0; m_run = 1'b1;
            acc = 4'hF; pend = 4'h0;
            for (int j = 0; j < 8; j++) hist[j] = 4'hF;
            return;
        end
        tk = m_run && (m_elapsed + 1 == (BT >> m_speed));
        mc = pend[0];
        pc = pend[3] && !mc;
        uc = pend[1] && !mc && !pend[3];
        dc = pend[2] && !mc && !pend[3] && !pend[1];
        if (mc) begin
            m_mode = (m_mode + 1) % 4;
            m_idx = 0;
        end else if (tk) m_idx++;
        if (mc || uc || dc) m_elapsed = 0;
        else if (m_run) m_elapsed = tk ? 0 : m_elapsed + 1;
        if (pc) m_run = !m_run;
        if (uc && m_speed < 3) m_speed++;
        if (dc && m_speed > 0) m_speed--;
        np = 4'h0;
        for (int i = 0; i < 4; i++) begin
            diff = 1'b1;
            for (int j = 1; j <= DC; j++) if (hist[j][i] == acc[i]) diff = 1'b0;
            if (diff) begin
                np[i] = acc[i];
                acc[i] = ~acc[i];
            end
        end
        pend = np;
        for (int j = 7; j > 0; j--) hist[j] = hist[j-1];
        hist[0] = key;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic cyc(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            model_edge();
            @(negedge clk);
            chk("model", {23'd0, led, mode, speed, running},
                {23'd0, mled(), 2'(m_mode), 2'(m_speed), m_run});
        end
    endtask

    task automatic press(input logic [3:0] mask, input int hold, input int gap);
        key = ~mask;
        cyc(hold);
        key = 4'hF;
        cyc(gap);
    endtask

    typedef struct {
        logic [3:0] k;
        int         n;
        logic [3:0] e_led;
        logic [1:0] e_mode;
        logic [1:0] e_speed;
        logic       e_run;
    } vec_t;

    vec_t vt [13];

    initial begin
        vt[0]  = '{4'hF,  8, 4'b0001, 2'd0, 2'd0, 1'b1};
        vt[1]  = '{4'hF,  8, 4'b0010, 2'd0, 2'd0, 1'b1};
        vt[2]  = '{4'hF, 16, 4'b0100, 2'd0, 2'd0, 1'b1};
        vt[3]  = '{4'hF, 15, 4'b0100, 2'd0, 2'd0, 1'b1};
        vt[4]  = '{4'hF,  1, 4'b1000, 2'd0, 2'd0, 1'b1};
        vt[5]  = '{4'hF, 16, 4'b0001, 2'd0, 2'd0, 1'b1};
        vt[6]  = '{4'hE,  6, 4'b0001, 2'd0, 2'd0, 1'b1};
        vt[7]  = '{4'hE,  1, 4'b0001, 2'd1, 2'd0, 1'b1};
        vt[8]  = '{4'hE,  3, 4'b0001, 2'd1, 2'd0, 1'b1};
        vt[9]  = '{4'hF, 12, 4'b0001, 2'd1, 2'd0, 1'b1};
        vt[10] = '{4'hF,  1, 4'b1000, 2'd1, 2'd0, 1'b1};
        vt[11] = '{4'hF, 16, 4'b0100, 2'd1, 2'd0, 1'b1};
        vt[12] = '{4'hF, 16, 4'b0010, 2'd1, 2'd0, 1'b1};

        res_n = 1'b0;
        key = 4'hF;
        cyc(1);
        chk("reset", {led, mode, speed, running}, {4'b0001, 2'd0, 2'd0, 1'b1});
        res_n = 1'b1;

        foreach (vt[i]) begin
            key = vt[i].k;
            cyc(vt[i].n);
            chk($sformatf("vec%0d", i), {led, mode, speed, running},
                {vt[i].e_led, vt[i].e_mode, vt[i].e_speed, vt[i].e_run});
        end

        press(4'b0001, 10, 10);
        press(4'b0001, 10, 10);
        chk("mode_pingpong", mode, 2'd3);
        cyc(120);
        for (int i = 0; i < 3; i++) press(4'b0001, 10, 10);
        chk("mode_blink", mode, 2'd2);
        cyc(50);

        for (int i = 0; i < 4; i++) press(4'b0010, 10, 10);
        chk("speed_max", speed, 2'd3);
        cyc(20);
        for (int i = 0; i < 5; i++) press(4'b0100, 10, 10);
        chk("speed_min", speed, 2'd0);

        cyc(5);
        press(4'b1000, 10, 0);
        chk("paused", running, 1'b0);
        cyc(100);
        chk("frozen_led", led, mled());
        press(4'b1000, 10, 30);
        chk("resumed", running, 1'b1);

        press(4'b0011, 10, 10);
        chk("prio_mode", mode, 2'd3);
        chk("prio_speed", speed, 2'd0);
        press(4'b1111, 10, 10);
        chk("prio_all_mode", {mode, speed, running}, {2'd0, 2'd0, 1'b1});

        for (int i = 0; i < 3; i++) press(4'b0001, 2, 3);
        cyc(20);
        chk("glitch", mode, 2'd0);

        press(4'b0001, 3, 0);
        cyc(7);
        res_n = 1'b0;
        cyc(1);
        chk("mid_reset", {led, mode, speed, running}, {4'b0001, 2'd0, 2'd0, 1'b1});
        res_n = 1'b1;
        cyc(20);

        for (int ev = 0; ev < 80; ev++) begin
            logic [3:0] mask;
            int hold;
            mask = 4'($urandom_range(0, 15));
            hold = $urandom_range(1, 12);
            for (int h = 0; h < hold; h++) begin
                key = ($urandom_range(0, 4) == 0) ? 4'($urandom) : ~mask;
                cyc(1);
            end
            key = 4'hF;
            cyc($urandom_range(1, 40));
            if ($urandom_range(0, 19) == 0) begin
                res_n = 1'b0;
                cyc(1);
                res_n = 1'b1;
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/led_mode_ctrl.md
Name: led_mode_ctrl

Overview:
- Controller that sequences the 4-LED display board through selectable patterns at selectable speeds under push-button control.
- Owns the step-tick timebase and the LED shift register; debounces four raw keys into single-cycle commands.
- Sits between the board keys and the LED pins; replaces the fixed-rate flow block as the top-level LED driver.

Parameters:
- BASE_TICK, 10_000_000, clock cycles per LED step at speed 0 (0.2 s at 50 MHz); must be < 2^24.
- DEB_CNT, 1_000_000, cycles a key must be stable before its level is accepted (20 ms at 50 MHz).

Ports:
- sys_clk  input  1  system clock
- sys_res_n  input  1  reset, synchronous, active-low
- key  input  4  raw buttons, active-low, asynchronous to sys_clk; [0] next mode, [1] speed up, [2] speed down, [3] pause/run toggle
- led  output  4  LED drive, 1 = on
- mode  output  2  current pattern: 0 FLOW_L, 1 FLOW_R, 2 BLINK, 3 PINGPONG
- speed  output  2  current speed level 0..3
- running  output  1  1 = stepping, 0 = paused

Behaviour:
- Reset (sys_res_n low at a sys_clk edge): led=4'b0001, mode=0, speed=0, running=1, tick counter=0, pingpong dir=left, all debounced key levels=1 (released), sync flops=1, debounce counters=0. Reset mid-pattern or mid-debounce discards all state; no command is emitted.
- Key input: 2-flop synchroniser per key. Per-key debounce counter clears whenever the synced level equals the accepted level; otherwise increments, and on reaching DEB_CNT-1 the accepted level takes the synced level and the counter clears. A 1->0 change of the accepted level produces a one-cycle press pulse. Release produces nothing. Minimum key-to-pulse latency = 2 + DEB_CNT cycles.
- Command priority when pulses coincide in one cycle: mode > pause > speed up > speed down; lower-priority pulses in that cycle are dropped.
- Mode pulse: mode <= mode+1 (3 wraps to 0); next cycle led loads its seed (FLOW_L/FLOW_R/PINGPONG: 0001; BLINK: 0000); dir=left; tick counter cleared. running unchanged.
- Pause pulse: running toggles. While running=0, tick counter and led hold.
- Speed up/down: speed saturates at 3/0 (no change, no wrap at limits); tick counter cleared on any accepted speed pulse, including a saturated one.
- Step period P = BASE_TICK >> speed (cycles). Tick counter counts 0..P-1 while running; tick asserted in the cycle counter==P-1; counter then returns to 0. If a speed change shortens P below the current count, the clear guarantees no overrun.
- On tick (and no mode pulse that cycle; mode pulse wins, tick is lost):
  - FLOW_L: led <= {led[2:0], led[3]}
  - FLOW_R: led <= {led[0], led[3:1]}
  - BLINK: led <= ~led
  - PINGPONG: one-hot bounce 0001->0010->0100->1000->0100->0010->0001->...; dir flips when the shifted value reaches 1000 or 0001; never wraps end to end.
- First step after reset occurs at cycle BASE_TICK (counter reaches BASE_TICK-1). led changes only on tick or mode change.
- mode, speed and running are registered and update the cycle after the pulse.

Test Plan (BASE_TICK=16, DEB_CNT=4 for sim):
- Reset then run 80 cycles, no keys -> led 0001,0010,0100,1000,0001 at 16-cycle intervals; mode=0, speed=0, running=1.
- Press key[0] once (held 10 cycles) -> mode=1, led=0001; subsequent steps 1000,0100,0010 every 16 cycles.
- Mode to 3 -> led sequence 0001,0010,0100,1000,0100,0010,0001,0010; mode to 2 -> led toggles 0000/1111 each step.
- key[1] pressed 4 times -> speed saturates at 3, step interval 2 cycles; key[2] pressed 5 times -> speed=0, interval 16.
- key[3] pressed mid-interval -> running=0, led frozen 100 cycles; press again -> resumes, next step after the remaining count.
- Key bounce of 2-cycle glitches -> no pulse; key[0] and key[1] released into press same cycle -> only mode advances, speed unchanged; sys_res_n low mid-pattern -> all outputs return to reset values next edge.
